// File: rtl/mainfsm_pkg.sv
// Shared types for the multicycle processor main controller: state encoding,
// instruction class codes and datapath select encodings.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Raw Moore control word, before enable gating.
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;
    logic       alu_op;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/mainfsm.sv
// Main multicycle control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing.
// Moore outputs; write enables gated by started & en, select lines ungated.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       ir_write,
  output logic       next_pc,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       alu_op,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state
);

  state_t cur, nxt;
  logic   started;
  logic   gate;
  ctrl_t  c;
  logic   unused_funct;

  assign unused_funct = ^funct[4:1];

  // started holds off the first advance so edge 1 after release only arms the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= S_FETCH;
      started <= 1'b0;
    end else if (en) begin
      started <= 1'b1;
      if (started) cur <= nxt;
    end
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  nxt = S_MEMADR;
          OP_DP:   nxt = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   nxt = S_BRANCH;
          default: nxt = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nxt = S_MEMWB;
      S_EXECUTER: nxt = S_ALUWB;
      S_EXECUTEI: nxt = S_ALUWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    c            = '0;
    c.alu_src_b  = SRCB_REG;
    c.result_src = RES_ALUOUT;
    case (cur)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECUTER: c.alu_op = 1'b1;
      S_EXECUTEI: begin
        c.alu_op    = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ALUWB:  c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
        c.branch     = 1'b1;
      end
      S_UNKNOWN: c.illegal = 1'b1;
      default: ;
    endcase
  end

  assign gate       = started & en;
  assign ir_write   = c.ir_write & gate;
  assign next_pc    = c.next_pc  & gate;
  assign reg_w      = c.reg_w    & gate;
  assign mem_w      = c.mem_w    & gate;
  assign branch     = c.branch   & gate;
  assign illegal    = c.illegal  & gate;
  assign alu_op     = c.alu_op;
  assign adr_src    = c.adr_src;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign result_src = c.result_src;
  assign state      = cur;

endmodule
